master_clock_enables: RTL

- Sits directly downstream of the master PLL and consumes its output clock and its lock indicator.
- Qualifies the PLL lock, generates the synchronous system reset, and derives PPU and CPU clock enables from the master clock.
- Downstream logic is clocked only by clk and advances only on these enables. The block also provides a debug pause/single-step facility at CPU-cycle granularity.

---
 rtl/master_clk_pkg.sv | 21 ++
 rtl/master_sync_ff.sv | 23 ++
 rtl/master_clock_enables.sv | 129 ++++++++++++
 3 files changed

// File: rtl/master_clk_pkg.sv
// Shared types and constants for the master clock-enable generator.
package master_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2
  } clk_state_e;

  localparam int PPU_DIV_NTSC = 4;
  localparam int CPU_DIV_NTSC = 12;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int PPU_CNT_W_NTSC = cnt_w(PPU_DIV_NTSC);
  localparam int CPU_CNT_W_NTSC = cnt_w(CPU_DIV_NTSC);

endpackage

// File: rtl/master_sync_ff.sv
// Multi-stage single-bit synchroniser with async active-low clear.
module master_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/master_clock_enables.sv
// PLL lock qualification, core reset generation and PPU/CPU clock enables
// with CPU-cycle-granular pause and single-step.
module master_clock_enables
  import master_clk_pkg::*;
#(
  parameter int PPU_DIV            = PPU_DIV_NTSC,
  parameter int CPU_DIV            = CPU_DIV_NTSC,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SYNC_STAGES        = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  input  logic pause,
  input  logic step,
  output logic sys_rst_n,
  output logic ppu_ce,
  output logic cpu_ce,
  output logic cpu_m2_ce,
  output logic paused
);

  localparam int PW = cnt_w(PPU_DIV);
  localparam int CW = cnt_w(CPU_DIV);
  localparam int SW = cnt_w(LOCK_STABLE_CYCLES + 1);
  localparam logic [PW-1:0] PPU_LAST = PW'(PPU_DIV - 1);
  localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DIV - 1);
  localparam logic [CW-1:0] CPU_MID  = CW'(CPU_DIV / 2 - 1);
  localparam logic [SW-1:0] STB_DONE = SW'(LOCK_STABLE_CYCLES);

  logic lk;

  master_sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  clk_state_e    state_q, state_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [PW-1:0] ppu_cnt_q, ppu_cnt_d;
  logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;
  logic          frozen_q, frozen_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          ppu_ce_q, ppu_ce_d;
  logic          cpu_ce_q, cpu_ce_d;
  logic          cpu_m2_ce_q, cpu_m2_ce_d;

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    case (state_q)
      WAIT_LOCK: if (lk) begin
        state_d  = STABILIZE;
        stable_d = SW'(1);
      end
      STABILIZE: begin
        if (!lk) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
        end else if (stable_q >= STB_DONE) begin
          state_d  = RUN;
          stable_d = '0;
        end else begin
          stable_d = stable_q + SW'(1);
        end
      end
      RUN:     if (!lk) state_d = WAIT_LOCK;
      default: begin
        state_d  = WAIT_LOCK;
        stable_d = '0;
      end
    endcase
  end

  // Freeze only takes effect on a CPU-cycle end, so counters restart from 0.
  // Leaving the freeze (release or step) also restarts from 0; a step simply
  // runs one CPU cycle and re-freezes through the normal pause path.
  always_comb begin
    frozen_d  = 1'b0;
    ppu_cnt_d = '0;
    cpu_cnt_d = '0;
    if (state_d == RUN && state_q == RUN) begin
      if (frozen_q) begin
        frozen_d = pause && !step;
      end else begin
        frozen_d  = cpu_ce_q && pause;
        ppu_cnt_d = (ppu_cnt_q == PPU_LAST) ? '0 : ppu_cnt_q + PW'(1);
        cpu_cnt_d = (cpu_cnt_q == CPU_LAST) ? '0 : cpu_cnt_q + CW'(1);
      end
    end
    sys_rst_n_d = (state_d == RUN);
    ppu_ce_d    = sys_rst_n_d && !frozen_d && (ppu_cnt_d == PPU_LAST);
    cpu_ce_d    = sys_rst_n_d && !frozen_d && (cpu_cnt_d == CPU_LAST);
    cpu_m2_ce_d = sys_rst_n_d && !frozen_d && (cpu_cnt_d == CPU_MID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      stable_q    <= '0;
      ppu_cnt_q   <= '0;
      cpu_cnt_q   <= '0;
      frozen_q    <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ppu_ce_q    <= 1'b0;
      cpu_ce_q    <= 1'b0;
      cpu_m2_ce_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stable_q    <= stable_d;
      ppu_cnt_q   <= ppu_cnt_d;
      cpu_cnt_q   <= cpu_cnt_d;
      frozen_q    <= frozen_d;
      sys_rst_n_q <= sys_rst_n_d;
      ppu_ce_q    <= ppu_ce_d;
      cpu_ce_q    <= cpu_ce_d;
      cpu_m2_ce_q <= cpu_m2_ce_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign ppu_ce    = ppu_ce_q;
  assign cpu_ce    = cpu_ce_q;
  assign cpu_m2_ce = cpu_m2_ce_q;
  assign paused    = frozen_q;

endmodule
